// File: rtl/ttt_move_input.sv
// Tic-tac-toe button front end: 2-flop sync, debounce, multi-press rejection, one-hot move strobe.
// Optional build macro TTT_OCCUPIED_FILTER_EN turns presses on taken cells into conflict strobes.
module ttt_move_input #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] btn_raw,
    input  logic [8:0] occupied,
    output logic       move_valid,
    output logic [8:0] move_pulse,
    output logic [3:0] move_cell,
    output logic       conflict,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        EMIT,
        WAIT_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [8:0]       btn_meta_reg;
    logic [8:0]       btn_s_reg;
    state_t           state_reg, state_next;
    logic [8:0]       sel_reg, sel_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             move_valid_reg, move_valid_next;
    logic [8:0]       move_pulse_reg, move_pulse_next;
    logic [3:0]       move_cell_reg, move_cell_next;
    logic             conflict_reg, conflict_next;
    logic             busy_reg, busy_next;

    logic             btn_any;
    logic             btn_multi;
    logic             sel_taken;
    logic [3:0]       sel_idx;
    logic [3:0]       idx_terms [9];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_reg <= 9'd0;
            btn_s_reg    <= 9'd0;
        end else begin
            btn_meta_reg <= btn_raw;
            btn_s_reg    <= btn_meta_reg;
        end
    end

    assign btn_any   = (btn_s_reg != 9'd0);
    assign btn_multi = ((btn_s_reg & (btn_s_reg - 9'd1)) != 9'd0);

    // sel_reg is one-hot, so OR-ing per-bit index terms yields its binary index
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_idx
            assign idx_terms[gi] = sel_reg[gi] ? 4'(gi) : 4'd0;
        end
    endgenerate

    always_comb begin
        sel_idx = 4'd0;
        for (int k = 0; k < 9; k++) begin
            sel_idx = sel_idx | idx_terms[k];
        end
    end

`ifdef TTT_OCCUPIED_FILTER_EN
    assign sel_taken = |(occupied & sel_reg);
`else
    logic unused_occupied;
    assign unused_occupied = ^occupied;
    assign sel_taken       = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        cnt_next        = cnt_reg;
        move_valid_next = 1'b0;
        move_pulse_next = 9'd0;
        move_cell_next  = 4'd0;
        conflict_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (btn_any && !btn_multi) begin
                    sel_next   = btn_s_reg;
                    cnt_next   = '0;
                    state_next = DEBOUNCE;
                end else if (btn_multi) begin
                    conflict_next = 1'b1;
                    cnt_next      = '0;
                    state_next    = WAIT_RELEASE;
                end
            end
            DEBOUNCE: begin
                if (btn_s_reg != sel_reg) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt_reg == CNT_MAX) begin
                    // Outputs are registered, so the EMIT-cycle strobe is decided here
                    state_next = EMIT;
                    if (sel_taken) begin
                        conflict_next = 1'b1;
                    end else begin
                        move_valid_next = 1'b1;
                        move_pulse_next = sel_reg;
                        move_cell_next  = sel_idx;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            EMIT: begin
                cnt_next   = '0;
                state_next = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (btn_any) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            sel_reg        <= 9'd0;
            cnt_reg        <= '0;
            move_valid_reg <= 1'b0;
            move_pulse_reg <= 9'd0;
            move_cell_reg  <= 4'd0;
            conflict_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            cnt_reg        <= cnt_next;
            move_valid_reg <= move_valid_next;
            move_pulse_reg <= move_pulse_next;
            move_cell_reg  <= move_cell_next;
            conflict_reg   <= conflict_next;
            busy_reg       <= busy_next;
        end
    end

    assign move_valid = move_valid_reg;
    assign move_pulse = move_pulse_reg;
    assign move_cell  = move_cell_reg;
    assign conflict   = conflict_reg;
    assign busy       = busy_reg;

endmodule
